// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush control slice.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DMEM_WAIT = 2'd1,
        ST_FAULT     = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector: the load in EX writes a register that the ID instruction reads.
import pipeline_ctrl_pkg::*;

module hazard_detection_unit (
    input  logic                  ID_EX_Memread,
    input  logic [REG_ADDR_W-1:0] ID_EX_Rd,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rs1,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rs2,
    output logic                  load_use
);

    // x0 is hardwired to zero, so a load that targets it never creates a dependency.
    assign load_use = ID_EX_Memread && (ID_EX_Rd != '0) &&
                      ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: merges load-use, taken-branch and dmem-wait conditions into
// per-stage enables, with a dmem watchdog and saturating stall/flush counters.
import pipeline_ctrl_pkg::*;

module pipeline_stall_controller #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DMEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ID_EX_Memread,
    input  logic [REG_ADDR_W-1:0] ID_EX_Rd,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rs1,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rs2,
    input  logic                  EX_Branch_Taken,
    input  logic                  EX_MEM_MemAccess,
    input  logic                  dmem_ready,
    output logic                  PC_Write,
    output logic                  IF_ID_Write,
    output logic                  IF_ID_Flush,
    output logic                  control_unit_select,
    output logic                  ID_EX_Write,
    output logic                  EX_MEM_Write,
    output logic                  MEM_WB_Bubble,
    output logic                  fault,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int unsigned WAIT_W = $clog2(DMEM_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WAIT_W-1:0] wait_inc;
    logic              load_use;
    logic              in_fault;
    logic              mem_stall;
    logic              branch_win;
    logic              stall_inc;

    hazard_detection_unit u_hdu (
        .ID_EX_Memread (ID_EX_Memread),
        .ID_EX_Rd      (ID_EX_Rd),
        .IF_ID_Rs1     (IF_ID_Rs1),
        .IF_ID_Rs2     (IF_ID_Rs2),
        .load_use      (load_use)
    );

    assign in_fault  = (state_q == ST_FAULT);
    assign mem_stall = ((state_q == ST_RUN) && EX_MEM_MemAccess && !dmem_ready) ||
                       ((state_q == ST_DMEM_WAIT) && !dmem_ready);
    assign wait_inc  = wait_q + WAIT_W'(1);

    // The timeout is judged on the incremented value so a release in the limit cycle still wins.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_RUN: begin
                if (EX_MEM_MemAccess && !dmem_ready) begin
                    state_d = ST_DMEM_WAIT;
                    wait_d  = '0;
                end
            end
            ST_DMEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = ST_RUN;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_W'(DMEM_TIMEOUT)) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        PC_Write            = 1'b1;
        IF_ID_Write         = 1'b1;
        IF_ID_Flush         = 1'b0;
        control_unit_select = 1'b0;
        ID_EX_Write         = 1'b1;
        EX_MEM_Write        = 1'b1;
        MEM_WB_Bubble       = 1'b0;
        branch_win          = 1'b0;
        if (rst || in_fault) begin
            PC_Write            = 1'b0;
            IF_ID_Write         = 1'b0;
            IF_ID_Flush         = 1'b1;
            control_unit_select = 1'b1;
            ID_EX_Write         = 1'b0;
            EX_MEM_Write        = 1'b0;
            MEM_WB_Bubble       = 1'b1;
        end else if (mem_stall) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Write  = 1'b0;
            MEM_WB_Bubble = 1'b1;
        end else if (EX_Branch_Taken) begin
            IF_ID_Flush         = 1'b1;
            control_unit_select = 1'b1;
            branch_win          = 1'b1;
        end else if (load_use) begin
            PC_Write            = 1'b0;
            IF_ID_Write         = 1'b0;
            control_unit_select = 1'b1;
        end
    end

    assign stall_inc = !rst && !in_fault && !PC_Write;
    assign fault     = in_fault;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (branch_win),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed-vector bench for pipeline_stall_controller (CNT_W=8, DMEM_TIMEOUT=4).
module tb_pipeline_stall_controller;

    // {PC_Write, IF_ID_Write, IF_ID_Flush, control_unit_select, ID_EX_Write, EX_MEM_Write, MEM_WB_Bubble}
    localparam logic [6:0] V_RESET  = 7'b0011001;
    localparam logic [6:0] V_MEMSTL = 7'b0000001;
    localparam logic [6:0] V_BRANCH = 7'b1111110;
    localparam logic [6:0] V_LDUSE  = 7'b0001110;
    localparam logic [6:0] V_NORMAL = 7'b1100110;

    logic       clk = 1'b0;
    logic       rst;
    logic       ID_EX_Memread;
    logic [4:0] ID_EX_Rd, IF_ID_Rs1, IF_ID_Rs2;
    logic       EX_Branch_Taken, EX_MEM_MemAccess, dmem_ready;
    logic       PC_Write, IF_ID_Write, IF_ID_Flush, control_unit_select;
    logic       ID_EX_Write, EX_MEM_Write, MEM_WB_Bubble, fault;
    logic [7:0] stall_cycles, flush_count;
    logic [6:0] ctl;

    int tests_run    = 0;
    int tests_failed = 0;

    pipeline_stall_controller #(.CNT_W(8), .DMEM_TIMEOUT(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ID_EX_Memread       (ID_EX_Memread),
        .ID_EX_Rd            (ID_EX_Rd),
        .IF_ID_Rs1           (IF_ID_Rs1),
        .IF_ID_Rs2           (IF_ID_Rs2),
        .EX_Branch_Taken     (EX_Branch_Taken),
        .EX_MEM_MemAccess    (EX_MEM_MemAccess),
        .dmem_ready          (dmem_ready),
        .PC_Write            (PC_Write),
        .IF_ID_Write         (IF_ID_Write),
        .IF_ID_Flush         (IF_ID_Flush),
        .control_unit_select (control_unit_select),
        .ID_EX_Write         (ID_EX_Write),
        .EX_MEM_Write        (EX_MEM_Write),
        .MEM_WB_Bubble       (MEM_WB_Bubble),
        .fault               (fault),
        .stall_cycles        (stall_cycles),
        .flush_count         (flush_count)
    );

    assign ctl = {PC_Write, IF_ID_Write, IF_ID_Flush, control_unit_select,
                  ID_EX_Write, EX_MEM_Write, MEM_WB_Bubble};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        ID_EX_Memread    = 1'b0;
        ID_EX_Rd         = 5'd0;
        IF_ID_Rs1        = 5'd0;
        IF_ID_Rs2        = 5'd0;
        EX_Branch_Taken  = 1'b0;
        EX_MEM_MemAccess = 1'b0;
        dmem_ready       = 1'b1;
    endtask

    task automatic set_hazard(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2);
        ID_EX_Memread = mr;
        ID_EX_Rd      = rd;
        IF_ID_Rs1     = rs1;
        IF_ID_Rs2     = rs2;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        settle();
        check("reset_ctl", 32'(ctl), 32'(V_RESET));
        tick();
        tick();
        check("reset_ctl_held", 32'(ctl), 32'(V_RESET));
        rst = 1'b0;
        settle();
        check("post_reset_ctl", 32'(ctl), 32'(V_NORMAL));
        check("post_reset_fault", 32'(fault), 32'd0);
        check("post_reset_stall", 32'(stall_cycles), 32'd0);
        check("post_reset_flush", 32'(flush_count), 32'd0);

        // lw x5 in EX, add x6,x5,x1 in ID
        tick();
        set_hazard(1'b1, 5'd5, 5'd5, 5'd1);
        settle();
        check("lu_rs1_ctl", 32'(ctl), 32'(V_LDUSE));
        tick();
        idle();
        settle();
        check("lu_release_ctl", 32'(ctl), 32'(V_NORMAL));
        check("lu_stall_cnt", 32'(stall_cycles), 32'd1);

        set_hazard(1'b1, 5'd7, 5'd3, 5'd7);
        settle();
        check("lu_rs2_ctl", 32'(ctl), 32'(V_LDUSE));
        tick();
        set_hazard(1'b0, 5'd7, 5'd7, 5'd7);
        settle();
        check("no_memread_ctl", 32'(ctl), 32'(V_NORMAL));
        tick();
        check("lu_rs2_stall_cnt", 32'(stall_cycles), 32'd2);

        set_hazard(1'b1, 5'd0, 5'd0, 5'd2);
        settle();
        check("rd0_ctl", 32'(ctl), 32'(V_NORMAL));
        tick();
        check("rd0_stall_cnt", 32'(stall_cycles), 32'd2);

        // Branch taken wins over load-use
        set_hazard(1'b1, 5'd5, 5'd5, 5'd1);
        EX_Branch_Taken = 1'b1;
        settle();
        check("br_lu_ctl", 32'(ctl), 32'(V_BRANCH));
        tick();
        idle();
        settle();
        check("br_flush_cnt", 32'(flush_count), 32'd1);
        check("br_stall_cnt", 32'(stall_cycles), 32'd2);

        // dmem low 3 cycles, then ready
        EX_MEM_MemAccess = 1'b1;
        dmem_ready       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("dmem_stall_ctl%0d", i), 32'(ctl), 32'(V_MEMSTL));
            tick();
        end
        dmem_ready = 1'b1;
        settle();
        check("dmem_release_ctl", 32'(ctl), 32'(V_NORMAL));
        tick();
        idle();
        settle();
        check("dmem_stall_cnt", 32'(stall_cycles), 32'd5);

        // Branch held during dmem stall: flushed only on the release cycle
        EX_MEM_MemAccess = 1'b1;
        dmem_ready       = 1'b0;
        EX_Branch_Taken  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check($sformatf("br_in_stall_ctl%0d", i), 32'(ctl), 32'(V_MEMSTL));
            tick();
            check($sformatf("br_in_stall_flush%0d", i), 32'(flush_count), 32'd1);
        end
        dmem_ready = 1'b1;
        settle();
        check("br_release_ctl", 32'(ctl), 32'(V_BRANCH));
        tick();
        idle();
        settle();
        check("br_release_flush", 32'(flush_count), 32'd2);
        check("br_release_stall", 32'(stall_cycles), 32'd7);

        // Release in the cycle the wait counter would reach the limit
        EX_MEM_MemAccess = 1'b1;
        dmem_ready       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("limit_stall_ctl%0d", i), 32'(ctl), 32'(V_MEMSTL));
            tick();
        end
        dmem_ready = 1'b1;
        settle();
        check("limit_release_ctl", 32'(ctl), 32'(V_NORMAL));
        tick();
        idle();
        settle();
        check("limit_no_fault", 32'(fault), 32'd0);
        check("limit_stall_cnt", 32'(stall_cycles), 32'd11);

        // Timeout: one RUN cycle plus four DMEM_WAIT cycles low, then FAULT
        EX_MEM_MemAccess = 1'b1;
        dmem_ready       = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("to_stall_ctl%0d", i), 32'(ctl), 32'(V_MEMSTL));
            check($sformatf("to_fault_low%0d", i), 32'(fault), 32'd0);
            tick();
        end
        check("to_fault", 32'(fault), 32'd1);
        check("to_fault_ctl", 32'(ctl), 32'(V_RESET));
        check("to_stall_cnt", 32'(stall_cycles), 32'd16);
        dmem_ready      = 1'b1;
        EX_Branch_Taken = 1'b1;
        settle();
        check("fault_br_ctl", 32'(ctl), 32'(V_RESET));
        tick();
        tick();
        check("fault_sticky", 32'(fault), 32'd1);
        check("fault_flush_frozen", 32'(flush_count), 32'd2);
        check("fault_stall_frozen", 32'(stall_cycles), 32'd16);

        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rerst_fault", 32'(fault), 32'd0);
        check("rerst_stall", 32'(stall_cycles), 32'd0);
        check("rerst_flush", 32'(flush_count), 32'd0);
        check("rerst_ctl", 32'(ctl), 32'(V_NORMAL));

        // Saturation of the 8-bit stall counter
        set_hazard(1'b1, 5'd9, 5'd9, 5'd0);
        for (int i = 0; i < 255; i++) tick();
        check("sat_reach", 32'(stall_cycles), 32'd255);
        for (int i = 0; i < 5; i++) tick();
        check("sat_hold", 32'(stall_cycles), 32'd255);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
